// File: rtl/mux_arbiter_4.sv
// Four-requester round-robin arbiter with a registered output stage.
// Payload of the winner is captured one cycle after acceptance and held until downstream takes it.

module mux_4 #(
    parameter int width = 32
) (
    input  logic [1:0]       sel,
    input  logic [width-1:0] d0,
    input  logic [width-1:0] d1,
    input  logic [width-1:0] d2,
    input  logic [width-1:0] d3,
    output logic [width-1:0] y
);

    // Plain 4:1 payload selector
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

module mux_arbiter_4 #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic [width-1:0] data_0,
    input  logic [width-1:0] data_1,
    input  logic [width-1:0] data_2,
    input  logic [width-1:0] data_3,
    output logic [3:0]       req_ready,
    output logic [width-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       select,
    output logic [3:0]       grant
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [3:0]       r_grant;
    logic [width-1:0] r_data;
    logic [1:0]       w_win;
    logic [3:0]       w_win_onehot;
    logic             w_load;
    logic [width-1:0] w_mux_data;

    // First set request bit searching upward from the pointer, wrapping mod 4.
    // Walking k downward leaves the lowest offset as the final assignment.
    function automatic logic [1:0] pick_winner(input logic [3:0] rq, input logic [1:0] p);
        logic [1:0] idx;
        pick_winner = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + k[1:0];
            if (rq[idx]) begin
                pick_winner = idx;
            end
        end
    endfunction

    assign w_win        = pick_winner(req, r_ptr);
    assign w_win_onehot = 4'b0001 << w_win;
    assign w_load       = reset_n && (req != 4'b0000) && ((r_state == IDLE) || out_ready);

    mux_4 #(.width(width)) u_mux_4 (
        .sel (w_win),
        .d0  (data_0),
        .d1  (data_1),
        .d2  (data_2),
        .d3  (data_3),
        .y   (w_mux_data)
    );

    // Next-state and accept strobe
    always_comb begin
        w_state_next = r_state;
        if (w_load) begin
            req_ready = w_win_onehot;
        end else begin
            req_ready = 4'b0000;
        end
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_next = HOLD;
                end else begin
                    w_state_next = IDLE;
                end
            end
            HOLD: begin
                if (w_load) begin
                    w_state_next = HOLD;
                end else if (out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = HOLD;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output stage and priority pointer; the pointer moves only on a load
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_sel   <= 2'd0;
            r_grant <= 4'b0000;
            r_ptr   <= 2'd0;
        end else if (w_load) begin
            r_data  <= w_mux_data;
            r_sel   <= w_win;
            r_grant <= w_win_onehot;
            r_ptr   <= w_win + 2'd1;
        end else if ((r_state == HOLD) && out_ready) begin
            r_grant <= 4'b0000;
        end
    end

    assign data_out  = r_data;
    assign select    = r_sel;
    assign grant     = r_grant;
    assign out_valid = (r_state == HOLD);

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Self-checking bench for mux_arbiter_4: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model.

module tb_mux_arbiter_4;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] data_0, data_1, data_2, data_3;
    logic [3:0]  req_ready;
    logic [31:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  select;
    logic [3:0]  grant;

    int total = 0;
    int bad   = 0;

    // Model state
    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_sel;

    mux_arbiter_4 #(.width(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .data_0    (data_0),
        .data_1    (data_1),
        .data_2    (data_2),
        .data_3    (data_3),
        .req_ready (req_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .select    (select),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] payload(input int i);
        case (i)
            0:       return data_0;
            1:       return data_1;
            2:       return data_2;
            default: return data_3;
        endcase
    endfunction

    // Round robin: scan the four positions starting at the pointer
    function automatic int model_winner();
        for (int k = 0; k < 4; k++) begin
            if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic bit model_load();
        return reset_n && (req != 4'b0000) && (!m_valid || out_ready);
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] v;
        v = 4'b0000;
        if (model_load()) v[model_winner()] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] exp_grant();
        logic [3:0] v;
        v = 4'b0000;
        if (m_valid) v[m_sel] = 1'b1;
        return v;
    endfunction

    // One clock edge: advance the model with the inputs seen at that edge
    task automatic cycle();
        int w;
        @(posedge clk);
        if (!reset_n) begin
            m_valid = 1'b0; m_data = 32'd0; m_sel = 0; m_ptr = 0;
        end else if (model_load()) begin
            w = model_winner();
            m_data = payload(w); m_sel = w; m_valid = 1'b1; m_ptr = (w + 1) % 4;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
        cycle(); cycle();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (data_out !== 32'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", data_out); end
        total++; if (select !== 2'd0) begin bad++; $display("FAIL reset_select got=%0d want=0", select); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        reset_n = 1'b0; req = 4'b1111; #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        cycle(); reset_n = 1'b1; req = 4'b0000; #1;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; data_0 = 32'd7; #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", req_ready); end
        cycle(); req = 4'b0000; #1;
        total++; if (out_valid !== 1'b1 || data_out !== 32'd7) begin bad++; $display("FAIL single_out got=%b/%0d want=1/7", out_valid, data_out); end
        total++; if (select !== 2'd0 || grant !== 4'b0001) begin bad++; $display("FAIL single_sel got=%0d/%b want=0/0001", select, grant); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [5];
        logic [3:0]  gseq [5];
        seq  = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd10};
        gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        data_0 = 32'd10; data_1 = 32'd11; data_2 = 32'd12; data_3 = 32'd13;
        req = 4'b1111; out_ready = 1'b1; #1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (data_out !== seq[i] || grant !== gseq[i] || out_valid !== 1'b1) begin
                bad++; $display("FAIL b2b_%0d got=%0d/%b want=%0d/%b", i, data_out, grant, seq[i], gseq[i]);
            end
            cycle();
        end
    endtask

    task automatic test_stall();
        do_reset();
        data_1 = 32'd11; req = 4'b0010; out_ready = 1'b0; #1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            req = 4'($urandom_range(0, 15)) ^ 4'(i); #1;
            total++;
            if (data_out !== 32'd11 || out_valid !== 1'b1 || req_ready !== 4'b0000 || grant !== 4'b0010) begin
                bad++; $display("FAIL stall_%0d got=%0d/%b/%b want=11/1/0000", i, data_out, out_valid, req_ready);
            end
            cycle();
        end
        req = 4'b0000; out_ready = 1'b1; #1;
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_pointer();
        do_reset();
        data_0 = 32'd100; data_3 = 32'd103;
        req = 4'b1000; out_ready = 1'b1; #1;
        cycle();
        req = 4'b1001; #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL ptr_ready0 got=%b want=0001", req_ready); end
        cycle();
        total++; if (data_out !== 32'd100 || select !== 2'd0) begin bad++; $display("FAIL ptr_win0 got=%0d/%0d want=100/0", data_out, select); end
        cycle();
        total++; if (data_out !== 32'd103 || select !== 2'd3) begin bad++; $display("FAIL ptr_win3 got=%0d/%0d want=103/3", data_out, select); end
        req = 4'b0000; cycle();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        data_1 = 32'd55; data_2 = 32'd66;
        req = 4'b0010; out_ready = 1'b0; #1;
        cycle();
        reset_n = 1'b0; req = 4'b0000; #1;
        cycle();
        total++; if (out_valid !== 1'b0 || data_out !== 32'd0 || grant !== 4'b0000) begin
            bad++; $display("FAIL midrst got=%b/%0d/%b want=0/0/0000", out_valid, data_out, grant);
        end
        reset_n = 1'b1; req = 4'b0110; #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL midrst_ready got=%b want=0010", req_ready); end
        req = 4'b0100; #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL midrst_ready2 got=%b want=0100", req_ready); end
        cycle(); req = 4'b0000; #1;
        total++; if (data_out !== 32'd66 || select !== 2'd2 || out_valid !== 1'b1) begin
            bad++; $display("FAIL midrst_win got=%0d/%0d want=66/2", data_out, select);
        end
    endtask

    task automatic test_idle();
        do_reset();
        data_1 = 32'd21; data_2 = 32'd22;
        req = 4'b0001; out_ready = 1'b1; #1;
        cycle(); req = 4'b0000; #1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL idle_%0d got=%b/%b want=0/0000", i, out_valid, req_ready);
            end
            cycle();
        end
        req = 4'b0110; #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL idle_ptr got=%b want=0010", req_ready); end
        cycle(); req = 4'b0000; cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req       = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            reset_n   = ($urandom_range(0, 39) != 0);
            data_0 = $urandom; data_1 = $urandom; data_2 = $urandom; data_3 = $urandom;
            #1;
            total++;
            if (req_ready !== exp_ready()) begin
                bad++; $display("FAIL rnd_ready_%0d got=%b want=%b", i, req_ready, exp_ready());
            end
            cycle();
            total++;
            if (out_valid !== m_valid || grant !== exp_grant() ||
                (m_valid && (data_out !== m_data || select !== 2'(m_sel)))) begin
                bad++; $display("FAIL rnd_out_%0d got=%b/%h/%0d/%b want=%b/%h/%0d/%b",
                    i, out_valid, data_out, select, grant, m_valid, m_data, m_sel, exp_grant());
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
        data_0 = 32'd0; data_1 = 32'd0; data_2 = 32'd0; data_3 = 32'd0;
        m_ptr = 0; m_valid = 1'b0; m_data = 32'd0; m_sel = 0;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_pointer();
        test_reset_mid_hold();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
